// File: rtl/freq_meas_scheduler.sv
// freq_meas_scheduler
//   Avalon-MM slave that time-shares one reciprocal frequency-counting
//   datapath across CHANNELS asynchronous frequency inputs. Each enabled
//   channel is measured in turn:
//     SYNC  : wait for the first rising edge (t0)
//     COUNT : run for GATE clocks
//     STOPW : wait for the stop edge (t1)
//     STORE : write the result pair to the channel slot
//   A scan that completes raises done and, when enabled, the IRQ.
//
// Ports
//   csi_MCLK_clk        system clock, all logic on the rising edge
//   rsi_MRST_reset      asynchronous active-high reset
//   avs_ctrl_address    register byte address
//   avs_ctrl_writedata  write data byte
//   avs_ctrl_write      write strobe
//   avs_ctrl_read       read strobe
//   avs_ctrl_readdata   registered read data, one cycle after the read strobe
//   ins_irq_irq         level interrupt, done & irq_en
//   freq_in             asynchronous frequency inputs, each below fclk/4
module freq_meas_scheduler #(
    parameter int CHANNELS = 4,
    parameter int GATE_W   = 24,
    parameter int CNT_W    = 32
) (
    input  logic                csi_MCLK_clk,
    input  logic                rsi_MRST_reset,
    input  logic [4:0]          avs_ctrl_address,
    input  logic [7:0]          avs_ctrl_writedata,
    input  logic                avs_ctrl_write,
    input  logic                avs_ctrl_read,
    output logic [7:0]          avs_ctrl_readdata,
    output logic                ins_irq_irq,
    input  logic [CHANNELS-1:0] freq_in
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam int               TW      = GATE_W + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_SYNC, S_COUNT, S_STOPW, S_STORE, S_NEXT
    } state_t;

    state_t state, next_state;

    logic                continuous, irq_en, done, busy;
    logic [7:0]          chmask, rsel;
    logic [GATE_W-1:0]   gate, gate_lat, gate_eff;
    logic [23:0]         gate_full;
    logic [CHANNELS-1:0] valid, en_mask;
    logic [31:0]         shadow_a, shadow_b, sel_a32, sel_b32;
    logic [CNT_W-1:0]    res_a [CHANNELS];
    logic [CNT_W-1:0]    res_b [CHANNELS];
    logic [CNT_W-1:0]    cnt_a, cnt_b, a_inc, b_inc, sel_a, sel_b;
    logic [TW-1:0]       timer, timer_inc, gate_ext;
    logic [2:0]          cur_ch, low_ch, next_ch, enter_ch;
    logic                next_found, has_en, pulse;
    logic [CHANNELS-1:0] sync1, sync2, sync3, edge_pulse;
    logic                start_req, abort_req, done_w1c;
    logic                enter_sync, clear_cnt, count_en, timer_step, timer_clr;
    logic                do_store, do_timeout, set_done, busy_set, busy_clr, scan_start;
    logic [7:0]          rd_mux;

    assign start_req  = avs_ctrl_write && (avs_ctrl_address == 5'd0) && avs_ctrl_writedata[0];
    assign abort_req  = avs_ctrl_write && (avs_ctrl_address == 5'd0) && avs_ctrl_writedata[3];
    assign done_w1c   = avs_ctrl_write && (avs_ctrl_address == 5'd2) && avs_ctrl_writedata[1];
    assign en_mask    = chmask[CHANNELS-1:0];
    assign has_en     = |en_mask;
    assign gate_full  = 24'(gate);
    // A zero gate would never close the window, so it behaves as one clock.
    assign gate_eff   = (gate == '0) ? GATE_W'(1) : gate;
    assign gate_ext   = {1'b0, gate_lat};
    assign timer_inc  = timer + 1'b1;
    assign edge_pulse = sync2 & ~sync3;
    assign a_inc      = (pulse && (cnt_a != CNT_MAX)) ? cnt_a + 1'b1 : cnt_a;
    assign b_inc      = (cnt_b != CNT_MAX) ? cnt_b + 1'b1 : cnt_b;
    assign sel_a32    = 32'(sel_a);
    assign sel_b32    = 32'(sel_b);
    assign ins_irq_irq = done & irq_en;

    // Two-flop synchroniser plus a third stage for rising-edge detection.
    always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
        if (rsi_MRST_reset) begin
            sync1 <= '0;
            sync2 <= '0;
            sync3 <= '0;
        end else begin
            sync1 <= freq_in;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    // Channel selection: lowest enabled channel, next enabled channel above
    // the current one, the current channel's edge pulse, and the RSEL result.
    always_comb begin
        low_ch     = '0;
        next_ch    = '0;
        next_found = 1'b0;
        pulse      = 1'b0;
        sel_a      = '0;
        sel_b      = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (en_mask[i]) begin
                low_ch = 3'(i);
            end
            if (en_mask[i] && (3'(i) > cur_ch)) begin
                next_ch    = 3'(i);
                next_found = 1'b1;
            end
        end
        for (int i = 0; i < CHANNELS; i++) begin
            if (cur_ch == 3'(i)) begin
                pulse = edge_pulse[i];
            end
            if (rsel == 8'(i)) begin
                sel_a = res_a[i];
                sel_b = res_b[i];
            end
        end
    end

    always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
        if (rsi_MRST_reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and datapath strobes. The cycle where timer reaches
    // the gate in COUNT may itself carry the stop edge; in STOPW the timer
    // restarts so the stop-edge wait is bounded by one more gate length.
    always_comb begin
        next_state = state;
        enter_sync = 1'b0;
        enter_ch   = cur_ch;
        clear_cnt  = 1'b0;
        count_en   = 1'b0;
        timer_step = 1'b0;
        timer_clr  = 1'b0;
        do_store   = 1'b0;
        do_timeout = 1'b0;
        set_done   = 1'b0;
        busy_set   = 1'b0;
        busy_clr   = 1'b0;
        scan_start = 1'b0;
        if (abort_req) begin
            next_state = S_IDLE;
            busy_clr   = 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_req) begin
                        if (has_en) begin
                            scan_start = 1'b1;
                            busy_set   = 1'b1;
                            enter_sync = 1'b1;
                            enter_ch   = low_ch;
                            next_state = S_SYNC;
                        end else begin
                            set_done = 1'b1;
                        end
                    end
                end
                S_SYNC: begin
                    if (pulse) begin
                        clear_cnt  = 1'b1;
                        timer_clr  = 1'b1;
                        next_state = S_COUNT;
                    end else if (timer_inc == gate_ext) begin
                        do_timeout = 1'b1;
                        next_state = S_NEXT;
                    end else begin
                        timer_step = 1'b1;
                    end
                end
                S_COUNT: begin
                    count_en   = 1'b1;
                    timer_step = 1'b1;
                    if (timer_inc == gate_ext) begin
                        if (pulse) begin
                            next_state = S_STORE;
                        end else begin
                            timer_clr  = 1'b1;
                            next_state = S_STOPW;
                        end
                    end
                end
                S_STOPW: begin
                    count_en = 1'b1;
                    if (pulse) begin
                        next_state = S_STORE;
                    end else if (timer_inc > gate_ext) begin
                        do_timeout = 1'b1;
                        next_state = S_NEXT;
                    end else begin
                        timer_step = 1'b1;
                    end
                end
                S_STORE: begin
                    do_store   = 1'b1;
                    next_state = S_NEXT;
                end
                S_NEXT: begin
                    if (next_found) begin
                        enter_sync = 1'b1;
                        enter_ch   = next_ch;
                        next_state = S_SYNC;
                    end else begin
                        set_done = 1'b1;
                        if (continuous && has_en) begin
                            enter_sync = 1'b1;
                            enter_ch   = low_ch;
                            next_state = S_SYNC;
                        end else begin
                            busy_clr   = 1'b1;
                            next_state = S_IDLE;
                        end
                    end
                end
                default: next_state = S_IDLE;
            endcase
        end
    end

    // Measurement datapath: gate latch, wait/gate timer, saturating
    // counters, per-channel result slots and valid bits.
    always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
        if (rsi_MRST_reset) begin
            cur_ch   <= '0;
            gate_lat <= '0;
            timer    <= '0;
            cnt_a    <= '0;
            cnt_b    <= '0;
            busy     <= 1'b0;
            valid    <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                res_a[i] <= '0;
                res_b[i] <= '0;
            end
        end else begin
            if (enter_sync) begin
                cur_ch   <= enter_ch;
                gate_lat <= gate_eff;
                timer    <= '0;
            end else if (timer_clr) begin
                timer <= '0;
            end else if (timer_step) begin
                timer <= timer_inc;
            end
            if (clear_cnt) begin
                cnt_a <= '0;
                cnt_b <= '0;
            end else if (count_en) begin
                cnt_a <= a_inc;
                cnt_b <= b_inc;
            end
            if (scan_start) begin
                valid <= valid & ~en_mask;
            end
            for (int i = 0; i < CHANNELS; i++) begin
                if (cur_ch == 3'(i) && (do_store || do_timeout)) begin
                    res_a[i] <= do_store ? cnt_a : '0;
                    res_b[i] <= do_store ? cnt_b : '0;
                    valid[i] <= do_store;
                end
            end
            if (busy_set) begin
                busy <= 1'b1;
            end else if (busy_clr) begin
                busy <= 1'b0;
            end
        end
    end

    // Read mux. Address 8 serves the live low byte of A while the same read
    // captures the full A/B pair, so 9..15 always belong to that pair.
    always_comb begin
        rd_mux = 8'h00;
        case (avs_ctrl_address)
            5'd0:  rd_mux = {5'b0, irq_en, continuous, 1'b0};
            5'd1:  rd_mux = chmask;
            5'd2:  rd_mux = {1'b0, cur_ch, 2'b00, done, busy};
            5'd3:  rd_mux = gate_full[7:0];
            5'd4:  rd_mux = gate_full[15:8];
            5'd5:  rd_mux = gate_full[23:16];
            5'd6:  rd_mux = rsel;
            5'd7:  rd_mux = 8'(valid);
            5'd8:  rd_mux = sel_a32[7:0];
            5'd9:  rd_mux = shadow_a[15:8];
            5'd10: rd_mux = shadow_a[23:16];
            5'd11: rd_mux = shadow_a[31:24];
            5'd12: rd_mux = shadow_b[7:0];
            5'd13: rd_mux = shadow_b[15:8];
            5'd14: rd_mux = shadow_b[23:16];
            5'd15: rd_mux = shadow_b[31:24];
            default: rd_mux = 8'h00;
        endcase
    end

    // Register bank writes, sticky done (set beats clear) and read data.
    always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
        if (rsi_MRST_reset) begin
            continuous        <= 1'b0;
            irq_en            <= 1'b0;
            chmask            <= '0;
            rsel              <= '0;
            gate              <= GATE_W'(24'h0F4240);
            done              <= 1'b0;
            shadow_a          <= '0;
            shadow_b          <= '0;
            avs_ctrl_readdata <= '0;
        end else begin
            if (avs_ctrl_write) begin
                case (avs_ctrl_address)
                    5'd0: begin
                        continuous <= avs_ctrl_writedata[1];
                        irq_en     <= avs_ctrl_writedata[2];
                    end
                    5'd1: chmask <= avs_ctrl_writedata;
                    5'd3: gate   <= GATE_W'({gate_full[23:8], avs_ctrl_writedata});
                    5'd4: gate   <= GATE_W'({gate_full[23:16], avs_ctrl_writedata, gate_full[7:0]});
                    5'd5: gate   <= GATE_W'({avs_ctrl_writedata, gate_full[15:0]});
                    5'd6: rsel   <= avs_ctrl_writedata;
                    default: ;
                endcase
            end
            if (set_done) begin
                done <= 1'b1;
            end else if (done_w1c) begin
                done <= 1'b0;
            end
            if (avs_ctrl_read) begin
                avs_ctrl_readdata <= rd_mux;
                if (avs_ctrl_address == 5'd8) begin
                    shadow_a <= sel_a32;
                    shadow_b <= sel_b32;
                end
            end
        end
    end

endmodule

// File: tb/tb_freq_meas_scheduler.sv
// Testbench for freq_meas_scheduler: register-map vector table followed by
// hand-written measurement, timeout, abort, snapshot and reset sequences.
module tb_freq_meas_scheduler;

    logic       clk;
    logic       rst;
    logic [4:0] address;
    logic [7:0] writedata;
    logic       write;
    logic       read;
    logic [7:0] readdata;
    logic       irq;
    logic [3:0] freq_in;

    int checks = 0;
    int errors = 0;
    int period [4];
    int phase  [4];

    typedef struct {
        logic [4:0] addr;
        logic       wr;
        logic [7:0] wdata;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[$];

    freq_meas_scheduler #(.CHANNELS(4), .GATE_W(24), .CNT_W(32)) dut (
        .csi_MCLK_clk      (clk),
        .rsi_MRST_reset    (rst),
        .avs_ctrl_address  (address),
        .avs_ctrl_writedata(writedata),
        .avs_ctrl_write    (write),
        .avs_ctrl_read     (read),
        .avs_ctrl_readdata (readdata),
        .ins_irq_irq       (irq),
        .freq_in           (freq_in)
    );

    // 10 ns system clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Square-wave sources: period[i] clocks per cycle, 0 holds the input low.
    initial begin
        freq_in = '0;
        for (int i = 0; i < 4; i++) begin
            period[i] = 0;
            phase[i]  = 0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                if (period[i] == 0) begin
                    phase[i]   = 0;
                    freq_in[i] = 1'b0;
                end else begin
                    phase[i]   = (phase[i] + 1) % period[i];
                    freq_in[i] = (phase[i] < period[i] / 2);
                end
            end
        end
    end

    // Hard stop in case a wait loop somehow never returns
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mkVec(input logic [4:0] a, input logic w,
                                   input logic [7:0] d, input logic [7:0] e);
        vec_t v;
        v.addr  = a;
        v.wr    = w;
        v.wdata = d;
        v.exp   = e;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One-cycle Avalon write
    task automatic applyStimulus(input logic [4:0] a, input logic [7:0] d);
        @(negedge clk);
        address   = a;
        writedata = d;
        write     = 1'b1;
        @(negedge clk);
        write     = 1'b0;
    endtask

    // Read with one-cycle latency; data sampled on the following falling edge
    task automatic readReg(input logic [4:0] a, output logic [7:0] d);
        @(negedge clk);
        address = a;
        read    = 1'b1;
        @(negedge clk);
        read    = 1'b0;
        d       = readdata;
    endtask

    task automatic setGate(input logic [23:0] g);
        applyStimulus(5'd3, g[7:0]);
        applyStimulus(5'd4, g[15:8]);
        applyStimulus(5'd5, g[23:16]);
    endtask

    task automatic waitDone(input string name);
        logic [7:0] s;
        int n;
        n = 0;
        do begin
            readReg(5'd2, s);
            n++;
        end while (!s[1] && n < 4000);
        checkOutput(name, 32'(s[1]), 32'd1);
    endtask

    // Reads the full A/B pair of the RSEL channel through addresses 8..15
    task automatic checkPair(input string name, input logic [31:0] ea, input logic [31:0] eb);
        logic [7:0]  b [8];
        logic [31:0] a_val, b_val;
        for (int i = 0; i < 8; i++) begin
            readReg(5'(8 + i), b[i]);
        end
        a_val = {b[3], b[2], b[1], b[0]};
        b_val = {b[7], b[6], b[5], b[4]};
        checkOutput({name, "_A"}, a_val, ea);
        checkOutput({name, "_B"}, b_val, eb);
    endtask

    initial begin
        logic [7:0] r;
        logic [7:0] sb [8];
        int n;

        rst       = 1'b1;
        address   = '0;
        writedata = '0;
        write     = 1'b0;
        read      = 1'b0;

        // Register map vectors: reset values, read/write, RO and unmapped
        vecs.push_back(mkVec(5'd0,  1'b0, 8'h00, 8'h00));
        vecs.push_back(mkVec(5'd1,  1'b0, 8'h00, 8'h00));
        vecs.push_back(mkVec(5'd2,  1'b0, 8'h00, 8'h00));
        vecs.push_back(mkVec(5'd3,  1'b0, 8'h00, 8'h40));
        vecs.push_back(mkVec(5'd4,  1'b0, 8'h00, 8'h42));
        vecs.push_back(mkVec(5'd5,  1'b0, 8'h00, 8'h0F));
        vecs.push_back(mkVec(5'd6,  1'b0, 8'h00, 8'h00));
        vecs.push_back(mkVec(5'd7,  1'b0, 8'h00, 8'h00));
        vecs.push_back(mkVec(5'd8,  1'b0, 8'h00, 8'h00));
        vecs.push_back(mkVec(5'd12, 1'b0, 8'h00, 8'h00));
        vecs.push_back(mkVec(5'd16, 1'b0, 8'h00, 8'h00));
        vecs.push_back(mkVec(5'd1,  1'b1, 8'hA5, 8'hA5));
        vecs.push_back(mkVec(5'd1,  1'b1, 8'h00, 8'h00));
        vecs.push_back(mkVec(5'd6,  1'b1, 8'h03, 8'h03));
        vecs.push_back(mkVec(5'd6,  1'b1, 8'h00, 8'h00));
        vecs.push_back(mkVec(5'd0,  1'b1, 8'h06, 8'h06));
        vecs.push_back(mkVec(5'd0,  1'b1, 8'h00, 8'h00));
        vecs.push_back(mkVec(5'd3,  1'b1, 8'h12, 8'h12));
        vecs.push_back(mkVec(5'd4,  1'b1, 8'h34, 8'h34));
        vecs.push_back(mkVec(5'd5,  1'b1, 8'h56, 8'h56));
        vecs.push_back(mkVec(5'd7,  1'b1, 8'hFF, 8'h00));
        vecs.push_back(mkVec(5'd2,  1'b1, 8'h01, 8'h00));
        vecs.push_back(mkVec(5'd20, 1'b1, 8'hFF, 8'h00));

        repeat (3) @(negedge clk);
        checkOutput("reset_irq", 32'(irq), 32'd0);
        checkOutput("reset_readdata", 32'(readdata), 32'd0);
        rst = 1'b0;

        $display("[TB] register map vectors");
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].wr) begin
                applyStimulus(vecs[i].addr, vecs[i].wdata);
            end
            readReg(vecs[i].addr, r);
            checkOutput($sformatf("vec%0d_addr%0d", i, vecs[i].addr), 32'(r), 32'(vecs[i].exp));
        end

        // GATE=1000, ch0 period 10, irq enabled: A=100, B=1000
        $display("[TB] single channel, gate 1000, period 10");
        period[0] = 10;
        setGate(24'd1000);
        applyStimulus(5'd1, 8'h01);
        applyStimulus(5'd0, 8'h05);
        waitDone("t1_done");
        readReg(5'd2, r);
        checkOutput("t1_status", 32'(r), 32'h02);
        checkOutput("t1_irq", 32'(irq), 32'd1);
        readReg(5'd7, r);
        checkOutput("t1_valid", 32'(r), 32'h01);
        checkPair("t1", 32'd100, 32'd1000);
        applyStimulus(5'd2, 8'h02);
        readReg(5'd2, r);
        checkOutput("t1_w1c", 32'(r), 32'h00);
        checkOutput("t1_irq_clr", 32'(irq), 32'd0);

        // CHMASK=0x05, ch2 held low times out in SYNC
        $display("[TB] ch0 measured, ch2 timeout");
        setGate(24'd200);
        applyStimulus(5'd1, 8'h05);
        applyStimulus(5'd0, 8'h01);
        waitDone("t3_done");
        readReg(5'd7, r);
        checkOutput("t3_valid", 32'(r), 32'h01);
        applyStimulus(5'd6, 8'h02);
        checkPair("t3_ch2", 32'd0, 32'd0);
        applyStimulus(5'd6, 8'h00);
        checkPair("t3_ch0", 32'd20, 32'd200);
        applyStimulus(5'd2, 8'h02);

        // Continuous ch0/ch1, abort during COUNT of ch1 in the second scan
        $display("[TB] continuous scan with abort");
        period[1] = 10;
        applyStimulus(5'd1, 8'h03);
        applyStimulus(5'd0, 8'h03);
        waitDone("t4_done");
        applyStimulus(5'd2, 8'h02);
        n = 0;
        do begin
            readReg(5'd2, r);
            n++;
        end while (!(r[6:4] == 3'd1 && r[0]) && n < 4000);
        checkOutput("t4_reach_ch1", 32'(r[6:4]), 32'd1);
        repeat (50) @(negedge clk);
        applyStimulus(5'd0, 8'h08);
        readReg(5'd2, r);
        checkOutput("t4_abort_busy", 32'(r[1:0]), 32'd0);
        repeat (300) @(negedge clk);
        readReg(5'd2, r);
        checkOutput("t4_no_new_done", 32'(r[1:0]), 32'd0);
        readReg(5'd7, r);
        checkOutput("t4_valid", 32'(r), 32'h03);
        applyStimulus(5'd6, 8'h01);
        checkPair("t4_ch1", 32'd20, 32'd200);

        // Snapshot coherency: read 8, rescan ch0 at period 7 / gate 100,
        // bytes 9..15 must still belong to the old pair (A=20, B=200)
        $display("[TB] shadow snapshot and period 7 measurement");
        applyStimulus(5'd6, 8'h00);
        readReg(5'd8, r);
        checkOutput("t5_snap_a0", 32'(r), 32'h14);
        period[0] = 7;
        setGate(24'd100);
        applyStimulus(5'd1, 8'h01);
        applyStimulus(5'd0, 8'h01);
        waitDone("t5_done");
        for (int i = 1; i < 8; i++) begin
            readReg(5'(8 + i), sb[i]);
        end
        checkOutput("t5_shadow_a", {sb[3], sb[2], sb[1]}, 32'd0);
        checkOutput("t5_shadow_b", {sb[7], sb[6], sb[5], sb[4]}, 32'd200);
        checkPair("t5_new", 32'd15, 32'd105);
        applyStimulus(5'd2, 8'h02);

        // Start with an empty mask: done without busy
        $display("[TB] empty channel mask");
        applyStimulus(5'd1, 8'h00);
        applyStimulus(5'd0, 8'h01);
        readReg(5'd2, r);
        checkOutput("t7_status", 32'(r[1:0]), 32'h2);

        // Reset asserted mid-COUNT clears outputs without a clock edge
        $display("[TB] asynchronous reset mid-measurement");
        period[0] = 10;
        applyStimulus(5'd0, 8'h04);
        checkOutput("t8_irq_before", 32'(irq), 32'd1);
        setGate(24'd1000);
        applyStimulus(5'd1, 8'h01);
        applyStimulus(5'd0, 8'h05);
        repeat (150) @(negedge clk);
        readReg(5'd3, r);
        checkOutput("t8_gate_lo", 32'(r), 32'hE8);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("t8_rst_readdata", 32'(readdata), 32'd0);
        checkOutput("t8_rst_irq", 32'(irq), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        readReg(5'd2, r);
        checkOutput("t8_status", 32'(r), 32'h00);
        readReg(5'd7, r);
        checkOutput("t8_valid", 32'(r), 32'h00);
        readReg(5'd3, r);
        checkOutput("t8_gate0", 32'(r), 32'h40);
        readReg(5'd4, r);
        checkOutput("t8_gate1", 32'(r), 32'h42);
        readReg(5'd5, r);
        checkOutput("t8_gate2", 32'(r), 32'h0F);
        applyStimulus(5'd6, 8'h00);
        checkPair("t8_res", 32'd0, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/freq_meas_scheduler.md
Name: freq_meas_scheduler

Overview:
- Qsys/Avalon-MM slave that time-shares one reciprocal frequency-counting datapath across CHANNELS external frequency inputs.
- Sequences each enabled channel in turn: input synchronisation, edge-aligned gate, stop-edge wait, timeout and result storage.
- Raises done/IRQ when a scan completes, so software reads per-channel results without re-arming a counter per input.
- Sits beside the existing frequency-measure slave on the same MCLK/MRST domain.

Parameters:
- CHANNELS, 4, number of frequency inputs (1..8).
- GATE_W, 24, width of gate-length register, in clocks.
- CNT_W, 32, width of per-channel edge count A and clock count B; counters saturate.

Ports:
- csi_MCLK_clk  in  1  system clock; all logic on rising edge.
- rsi_MRST_reset  in  1  asynchronous, active-high reset.
- avs_ctrl_address  in  5  register byte address.
- avs_ctrl_writedata  in  8  write data.
- avs_ctrl_write  in  1  write strobe.
- avs_ctrl_read  in  1  read strobe.
- avs_ctrl_readdata  out  8  registered read data, 1-cycle latency.
- ins_irq_irq  out  1  level interrupt = done & irq_en.
- freq_in  in  CHANNELS  asynchronous frequency inputs, each below fclk/4.

Behaviour:
- Register map, 8-bit:
  - 0 CTRL: b0 start (W1 pulse), b1 continuous, b2 irq_en, b3 abort (W1 pulse).
  - 1 CHMASK: channel enables.
  - 2 STATUS: b0 busy (RO), b1 done (sticky, W1C), b6:4 current channel (RO).
  - 3..5 GATE, little-endian; reset value 0x0F4240.
  - 6 RSEL: result channel select.
  - 7 VALID: RO, per-channel valid bits.
  - 8..11 A, 12..15 B: little-endian shadow of the RSEL channel.
  - Other addresses read 0; writes to them are ignored.
- Reset: all registers to 0 except GATE; readdata=0, irq=0, FSM in IDLE, stored results 0.
- Read of address 8 snapshots A and B of the RSEL channel into a shadow register in the same cycle. Addresses 9..15 return shadow bytes, so a 32-bit pair is always coherent.
- Input handling: each freq_in passes through a 2-FF synchroniser, then a rising-edge detector giving a 1-clk pulse. Only the selected channel's pulse is used.
- FSM states:
  - IDLE: on start, clear VALID bits of enabled channels, set busy, pick the lowest enabled channel and go to SYNC. If CHMASK=0: set done next cycle, busy stays 0. Start while busy is ignored.
  - SYNC: latch GATE and clear wait timer on entry. First edge pulse is t0: clear A, B and timer, go to COUNT. If the wait timer reaches GATE with no edge: timeout.
  - COUNT: each cycle B+=1 and timer+=1; each edge pulse A+=1. When timer==GATE, go to STOPW; the cycle at t0+GATE is itself eligible as the stop edge.
  - STOPW: keep counting. First edge pulse at cycle t1 ≥ t0+GATE ends the window and goes to STORE. Wait >GATE clocks with no edge: timeout.
  - Result definitions: A = number of edge pulses in (t0, t1]; B = t1 − t0.
  - STORE (1 cycle): write A and B to the channel slot, set VALID[ch], go to NEXT.
  - Timeout: store A=B=0, VALID[ch]=0, go to NEXT.
  - NEXT: re-sample CHMASK and go to the next higher enabled channel's SYNC. If none remain, set done; if continuous, restart from the lowest enabled channel, else go to IDLE with busy=0.
- Abort: FSM to IDLE within 1 clk, busy=0, current channel not stored, done unchanged. Abort takes priority over a simultaneous start.
- GATE/CHMASK writes while busy take effect at the next SYNC entry / NEXT evaluation. GATE=0 is treated as 1.
- A and B saturate at 2^CNT_W−1, with no wrap.
- Simultaneous done set and W1C in the same cycle: set wins.
- Write and read in the same cycle: write takes effect; readdata returns the pre-write value.

Test Plan:
- GATE=1000, CHMASK=0x01, freq_in[0] period 10 clk, start: done=1, VALID=0x01, A=100, B=1000; irq=1 if irq_en=1.
- GATE=100, freq_in[0] period 7 clk: stop edge at t0+105, so A=15, B=105.
- CHMASK=0x05, GATE=200, freq_in[0] period 10, freq_in[2] held low: ch0 stored, ch2 times out after 200 clk in SYNC; VALID=0x01, RSEL=2 reads A=B=0.
- Continuous mode with ch0/ch1 active; write abort during COUNT of ch1: busy=0 next cycle, ch1 results and VALID[1] unchanged, no new done.
- Read addr 8 with RSEL=0, then let a new scan overwrite ch0 before reading 9..15: the bytes still match the snapshot pair.
- Assert rsi_MRST_reset mid-COUNT: readdata=0, irq=0, busy=0, VALID=0, GATE=0x0F4240 immediately, without waiting for a clock edge.
